typed_alias_pipe: RTL and testbench

//   Parametrised, registered successor to the combinational enum->alias->struct

---
 rtl/typed_alias_pipe.sv | 99 +++++++++
 tb/tb_typed_alias_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typed_alias_pipe.sv
// typed_alias_pipe
//   Registered valid/ready pipeline that carries NUM_CH lanes of enum codes
//   through DEPTH stages and presents them re-typed as struct fields (same
//   bits). Each lane is flagged at entry when its code is outside the legal
//   range 0..NUM_LEG-1, and a saturating counter tallies accepted beats that
//   held at least one illegal lane.
module typed_alias_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 2,
    parameter int NUM_LEG = 3,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0]        out_illeg,
    output logic [CNT_W-1:0]         illeg_cnt,
    input  logic                     cnt_clr
);

    localparam int DW = NUM_CH * WIDTH;

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  adv;
    logic [DW-1:0]     dat [DEPTH];
    logic [NUM_CH-1:0] ilg [DEPTH];
    logic [NUM_CH-1:0] illeg_in;
    logic              chain;
    logic              in_fire;
    logic [CNT_W-1:0]  cnt;

    // Per-lane legality of the incoming codes; widened so NUM_LEG == 2**WIDTH works.
    always_comb begin
        illeg_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            illeg_in[k] = (33'(in_data[k*WIDTH +: WIDTH]) >= 33'(NUM_LEG));
        end
    end

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        adv   = '0;
        chain = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = chain | ~vld[i];
            adv[i] = chain;
        end
    end

    assign in_ready = adv[0];
    assign in_fire  = in_valid & adv[0];

    // Stage registers: s0 captures the input beat, later stages shift forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
                ilg[i] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
                dat[0] <= in_data;
                ilg[0] <= illeg_in;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                    ilg[i] <= ilg[i-1];
                end
            end
        end
    end

    // Saturating count of accepted beats with any illegal lane; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (in_fire && (|illeg_in) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign out_illeg = ilg[DEPTH-1];
    assign illeg_cnt = cnt;

endmodule

// File: tb/tb_typed_alias_pipe.sv
// tb_typed_alias_pipe
//   Directed bench for typed_alias_pipe (DEPTH=2, two 8-bit lanes, 2-bit counter).
//   A beat-queue model predicts ordering, data, flags, readiness, latency and
//   the illegal-beat count; literal checks pin the model at key points.
module tb_typed_alias_pipe;

    localparam int WIDTH   = 8;
    localparam int NUM_CH  = 2;
    localparam int DEPTH   = 2;
    localparam int NUM_LEG = 3;
    localparam int CNT_W   = 2;
    localparam int DW      = NUM_CH * WIDTH;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [NUM_CH-1:0] out_illeg;
    logic [CNT_W-1:0]  illeg_cnt;
    logic              cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typed_alias_pipe #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .NUM_LEG(NUM_LEG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_illeg(out_illeg), .illeg_cnt(illeg_cnt), .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lane k is illegal when its numeric code is not one of 0..NUM_LEG-1.
    function automatic logic [NUM_CH-1:0] illeg_of(input logic [DW-1:0] d);
        logic [NUM_CH-1:0] r;
        int code;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            code = int'((d >> (k * WIDTH)) & 16'h00FF);
            r[k] = (code >= NUM_LEG);
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0]     d;
        logic [NUM_CH-1:0] il;
        int                acc;
        bit                clean;
    } beat_t;

    beat_t q[$];
    int    cyc     = 0;
    int    cnt_m   = 0;
    bit    started = 0;

    // Model: beats in flight form a FIFO; the pipe holds at most DEPTH of them.
    always @(negedge clk) begin
        bit    exp_ready;
        bit    acc;
        beat_t b;
        exp_ready = 1'b0;
        if (started) begin
            exp_ready = out_ready || (q.size() < DEPTH);
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("illeg_cnt_model", 32'(illeg_cnt), 32'(cnt_m));
            if (q.size() == 0) begin
                check("no_spurious_out", 32'(out_valid), 32'd0);
            end else begin
                if (q[0].clean && cyc <= q[0].acc + DEPTH)
                    check("latency", 32'(out_valid), 32'(cyc == q[0].acc + DEPTH));
                if (out_valid) begin
                    check("out_data_model", 32'(out_data), 32'(q[0].d));
                    check("out_illeg_model", 32'(out_illeg), 32'(q[0].il));
                end
            end
        end
        if (!rst_n) begin
            q.delete();
            cnt_m   = 0;
            started = 1;
        end else if (started) begin
            acc = in_valid && exp_ready;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (!out_ready) foreach (q[i]) q[i].clean = 1'b0;
            if (acc) begin
                b.d     = in_data;
                b.il    = illeg_of(in_data);
                b.acc   = cyc;
                b.clean = 1'b1;
                q.push_back(b);
            end
            if (cnt_clr) cnt_m = 0;
            else if (acc && illeg_of(in_data) != 0 && cnt_m < (1 << CNT_W) - 1) cnt_m++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("accept_in_time", 32'(ok), 32'd1);
    endtask

    logic [DW-1:0] mix_tbl [8];
    logic [19:0]   rdy_pat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mix_tbl = '{16'h0001, 16'h0302, 16'h0000, 16'hFF01, 16'h0102, 16'h0200, 16'h0404, 16'h0101};
        rdy_pat = 20'b1011_0010_1110_0101_1101;

        // 1: reset with in_valid held high
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1; cnt_clr = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_illeg_cnt", 32'(illeg_cnt), 32'd0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_data", 32'(out_data), 32'd0);
        check("rel_out_illeg", 32'(out_illeg), 32'd0);

        // 2: streaming, two legal beats back to back
        tick();
        in_valid = 1'b1; in_data = 16'h0200;
        tick();
        in_data = 16'h0101;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_b0_valid", 32'(out_valid), 32'd1);
        check("stream_b0_data", 32'(out_data), 32'h0200);
        check("stream_b0_illeg", 32'(out_illeg), 32'd0);
        tick();
        @(negedge clk);
        check("stream_b1_data", 32'(out_data), 32'h0101);
        check("stream_b1_illeg", 32'(out_illeg), 32'd0);

        // 3: illegal codes
        tick();
        in_valid = 1'b1; in_data = 16'h0301;
        tick();
        in_data = 16'hFFFF;
        @(negedge clk);
        check("illeg_cnt_1", 32'(illeg_cnt), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("illeg_cnt_2", 32'(illeg_cnt), 32'd2);
        check("illeg_b0_data", 32'(out_data), 32'h0301);
        check("illeg_b0_flags", 32'(out_illeg), 32'b10);
        tick();
        @(negedge clk);
        check("illeg_b1_flags", 32'(out_illeg), 32'b11);

        // 4: backpressure, two beats fill the pipe, third must wait
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
        tick();
        in_data = 16'h0102;
        tick();
        in_data = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_frozen_data", 32'(out_data), 32'h0001);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        in_data = 16'h0101;
        @(negedge clk);
        check("bp_beat2", 32'(out_data), 32'h0102);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_beat3", 32'(out_data), 32'h0200);
        tick();
        @(negedge clk);
        check("bp_beat4", 32'(out_data), 32'h0101);

        // 5: saturation and clear
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt", 32'(illeg_cnt), 32'd0);
        tick();
        in_valid = 1'b1; in_data = 16'h0300;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_cnt", 32'(illeg_cnt), 32'd3);
        tick();
        in_valid = 1'b1; in_data = 16'h0500; cnt_clr = 1'b1;
        tick();
        in_valid = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_beats_inc", 32'(illeg_cnt), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // 6: reset mid-flight
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0002;
        tick();
        in_data = 16'h0100;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b1; in_data = 16'h0201;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_early", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h0201);

        // 7: mixed stream against a toggling out_ready
        tick();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    tick();
                    out_ready = rdy_pat[i];
                end
                tick();
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) drive_beat(mix_tbl[i]);
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
        tick();
        @(negedge clk);
        check("drain_all_delivered", 32'(q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
